riscv_core_muldiv_unit: RTL

- Iterative sequencer and datapath for the RV64 "M" extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, plus the word forms MULW, DIVW, DIVUW, REMW and REMUW.
- Sits beside the integer ALU in the execute stage. When the ALU decoder flags an M-class op (funct7 = 0000001), funct3 and the operands are handed here.
- Stalls the pipeline via o_muldiv_busy until it returns a single-cycle o_muldiv_done with the result.

---
 rtl/riscv_core_muldiv_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/riscv_core_muldiv_unit.sv
// rtl/riscv_core_muldiv_unit.sv - iterative RV64 M-extension multiply/divide unit
// Optional single-cycle multiplier: define RISCV_CORE_MULDIV_FAST_MUL_EN
module riscv_core_muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            i_muldiv_clk,
  input  logic            i_muldiv_rst,
  input  logic            i_muldiv_start,
  input  logic [2:0]      i_muldiv_funct3,
  input  logic            i_muldiv_word,
  input  logic [XLEN-1:0] i_muldiv_rs1,
  input  logic [XLEN-1:0] i_muldiv_rs2,
  input  logic            i_muldiv_kill,
  output logic            o_muldiv_ready,
  output logic            o_muldiv_busy,
  output logic            o_muldiv_done,
  output logic [XLEN-1:0] o_muldiv_result
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [2:0]      f3_q;
  logic            word_q, negq_q, negr_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q, result_q;
  logic [CW-1:0]   cnt_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] mul_pick(input logic [1:0] sel, input logic word,
                                               input logic neg, input logic [2*XLEN-1:0] prod);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    if (word) return sext32(p[31:0]);
    return (sel == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  logic            accept, is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic            div_zero, div_ovf, mul_zero, mul_rsvd, special, fast_mul;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, spec_raw, spec_res, fast_res;

  assign accept = i_muldiv_start && (state_q == IDLE) && !i_muldiv_kill;
  assign is_div = i_muldiv_funct3[2];
  assign sgn_a  = !(i_muldiv_funct3 inside {3'd3, 3'd5, 3'd7});
  assign sgn_b  = i_muldiv_funct3 inside {3'd0, 3'd1, 3'd4, 3'd6};

  assign a_ext = !i_muldiv_word ? i_muldiv_rs1 :
                 sgn_a ? sext32(i_muldiv_rs1[31:0]) : {{(XLEN-32){1'b0}}, i_muldiv_rs1[31:0]};
  assign b_ext = !i_muldiv_word ? i_muldiv_rs2 :
                 sgn_b ? sext32(i_muldiv_rs2[31:0]) : {{(XLEN-32){1'b0}}, i_muldiv_rs2[31:0]};
  assign a_neg = sgn_a && a_ext[XLEN-1];
  assign b_neg = sgn_b && b_ext[XLEN-1];
  assign mag_a = a_neg ? -a_ext : a_ext;
  assign mag_b = b_neg ? -b_ext : b_ext;

  // Operands are already extended to the op width, so one compare covers both forms.
  assign div_zero = is_div && (b_ext == '0);
  assign div_ovf  = is_div && sgn_a && (b_ext == '1) &&
                    (a_ext == (i_muldiv_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
  assign mul_zero = !is_div && ((a_ext == '0) || (b_ext == '0));
  assign mul_rsvd = !is_div && i_muldiv_word && (i_muldiv_funct3[1:0] != 2'd0);
  assign special  = div_zero || div_ovf || mul_zero || mul_rsvd;

  assign spec_raw = div_zero ? (i_muldiv_funct3[1] ? i_muldiv_rs1 : '1) :
                    (div_ovf && !i_muldiv_funct3[1]) ? i_muldiv_rs1 : '0;
  assign spec_res = i_muldiv_word ? sext32(spec_raw[31:0]) : spec_raw;

`ifdef RISCV_CORE_MULDIV_FAST_MUL_EN
  assign fast_mul = !is_div;
  assign fast_res = mul_pick(i_muldiv_funct3[1:0], i_muldiv_word, a_neg ^ b_neg,
                             {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b});
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  logic [XLEN:0]   sum, shifted, diff;
  logic [XLEN-1:0] hi_nx, lo_nx, quo, rem, div_raw, calc_res;

  // hi:lo is the product accumulator (multiply) or remainder:quotient shifter (divide).
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    if (f3_q[2]) begin
      hi_nx = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], lo_q[XLEN-1:1]};
    end
    quo     = negq_q ? -lo_nx : lo_nx;
    rem     = negr_q ? -hi_nx : hi_nx;
    div_raw = f3_q[1] ? rem : quo;
    if (f3_q[2])
      calc_res = word_q ? sext32(div_raw[31:0]) : div_raw;
    else
      calc_res = mul_pick(f3_q[1:0], word_q, negq_q,
                          word_q ? {{(2*XLEN-32){1'b0}}, lo_nx[XLEN-1 -: 32]} : {hi_nx, lo_nx});
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (special || fast_mul) ? DONE : CALC;
      CALC:    if (i_muldiv_kill) state_d = IDLE;
               else if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_muldiv_clk) begin
    if (i_muldiv_rst) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_ff @(posedge i_muldiv_clk) begin
    if (i_muldiv_rst) begin
      f3_q     <= '0;
      word_q   <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      f3_q   <= i_muldiv_funct3;
      word_q <= i_muldiv_word;
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
      hi_q   <= '0;
      b_q    <= is_div ? mag_b : mag_a;
      // Word divides start with the dividend at the top so 32 shifts consume it.
      lo_q   <= !is_div ? mag_b :
                i_muldiv_word ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
      cnt_q  <= i_muldiv_word ? CW'(31) : CW'(XLEN-1);
      if (special)       result_q <= spec_res;
      else if (fast_mul) result_q <= fast_res;
    end else if (state_q == CALC && !i_muldiv_kill) begin
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) result_q <= calc_res;
    end
  end

  assign o_muldiv_ready  = (state_q == IDLE);
  assign o_muldiv_busy   = (state_q != IDLE);
  assign o_muldiv_done   = (state_q == DONE) && !i_muldiv_kill;
  assign o_muldiv_result = result_q;
endmodule
